// File: rtl/nonconsec_mon_pkg.sv
// Shared types and helpers for the non-consecutive repetition monitor:
// FSM state encoding, count-width helper and the saturating increment.
package nonconsec_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int REP_N_DEF    = 3;
  localparam int MAX_WAIT_DEF = 64;
  localparam int CNT_W_DEF    = 16;

  // Bits needed to hold values 0..max_val; used as $clog2(REP_N+1) and $clog2(MAX_WAIT+1).
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int B_CNT_W_DEF    = cnt_width(REP_N_DEF);
  localparam int WAIT_CNT_W_DEF = cnt_width(MAX_WAIT_DEF);

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/nonconsec_rep_monitor_sat_counter.sv
// Saturating statistics counter with synchronous clear.
module sat_counter
  import nonconsec_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
    end
  end

endmodule

// File: rtl/nonconsec_rep_monitor.sv
// Run-time checker: A, then B seen exactly REP_N times (not necessarily
// back to back) implies C high at every match point.
module nonconsec_rep_monitor
  import nonconsec_mon_pkg::*;
#(
  parameter int REP_N    = REP_N_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             vacuous_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int B_W = cnt_width(REP_N);
  localparam int W_W = cnt_width(MAX_WAIT);

  state_t         state, state_nxt;
  logic [B_W-1:0] b_cnt, b_cnt_nxt, b_cnt_inc;
  logic [W_W-1:0] wait_cnt, wait_cnt_nxt;
  logic           pass_nxt, fail_nxt, vacuous_nxt;
  logic           drop;

  assign b_cnt_inc = b_cnt + 1'b1;
  assign busy_o    = (state != IDLE);
  // A trigger is dropped whenever an attempt is outstanding, even on its last cycle.
  assign drop      = en_i && a_i && (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_nxt    = state;
    b_cnt_nxt    = b_cnt;
    wait_cnt_nxt = wait_cnt;
    pass_nxt     = 1'b0;
    fail_nxt     = 1'b0;
    vacuous_nxt  = 1'b0;

    if (!en_i) begin
      state_nxt    = IDLE;
      b_cnt_nxt    = '0;
      wait_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (a_i) begin
            state_nxt    = COUNT;
            b_cnt_nxt    = '0;
            wait_cnt_nxt = '0;
          end
        end
        COUNT: begin
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (b_i) b_cnt_nxt = b_cnt_inc;
          // A completing B beats the timeout on the same cycle.
          if (b_i && (b_cnt_inc == B_W'(REP_N))) begin
            if (c_i) begin
              pass_nxt  = 1'b1;
              state_nxt = CHECK;
            end else begin
              fail_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end else if (wait_cnt_nxt == W_W'(MAX_WAIT)) begin
            vacuous_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
        CHECK: begin
          if (b_i) begin
            state_nxt = IDLE;
          end else if (c_i) begin
            pass_nxt = 1'b1;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b_cnt     <= '0;
      wait_cnt  <= '0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      vacuous_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      b_cnt     <= b_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      pass_o    <= pass_nxt;
      fail_o    <= fail_nxt;
      vacuous_o <= vacuous_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .clr (rst),
    .inc (pass_nxt),
    .cnt (pass_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .clr (rst),
    .inc (fail_nxt),
    .cnt (fail_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .clr (rst),
    .inc (drop),
    .cnt (drop_cnt_o)
  );

endmodule

// File: tb/tb_nonconsec_rep_monitor.sv
// Scoreboard bench: a cycle model pushes expected outputs as stimulus is
// driven; they are popped and compared after the following clock edge.
module tb_nonconsec_rep_monitor;

  localparam int REP_N    = 3;
  localparam int MAX_WAIT = 64;
  localparam int BIG_MAX  = 65535;
  localparam int SML_MAX  = 15;

  logic        clk = 1'b0;
  logic        rst, en_i, a_i, b_i, c_i;
  logic        busy_o, pass_o, fail_o, vacuous_o;
  logic [15:0] pass_cnt_o, fail_cnt_o, drop_cnt_o;
  logic        s_busy, s_pass, s_fail, s_vac;
  logic [3:0]  s_pass_cnt, s_fail_cnt, s_drop_cnt;

  always #5 clk = ~clk;

  nonconsec_rep_monitor #(.REP_N(REP_N), .MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o), .vacuous_o(vacuous_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  nonconsec_rep_monitor #(.REP_N(REP_N), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .en_i(en_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .busy_o(s_busy), .pass_o(s_pass), .fail_o(s_fail), .vacuous_o(s_vac),
    .pass_cnt_o(s_pass_cnt), .fail_cnt_o(s_fail_cnt), .drop_cnt_o(s_drop_cnt)
  );

  typedef struct {
    bit busy, pass, fail, vac;
    int pc, fc, dc, spc, sfc, sdc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: 0 idle, 1 counting, 2 checking.
  int m_st, m_b, m_w, m_pc, m_fc, m_dc, m_spc, m_sfc, m_sdc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  task automatic model_reset();
    exp_t e;
    m_st = 0; m_b = 0; m_w = 0;
    m_pc = 0; m_fc = 0; m_dc = 0; m_spc = 0; m_sfc = 0; m_sdc = 0;
    e = '{default: 0};
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit en, input bit a, input bit b, input bit c);
    exp_t e;
    e = '{default: 0};
    if (en && a && m_st != 0) begin
      m_dc = sat(m_dc, BIG_MAX); m_sdc = sat(m_sdc, SML_MAX);
    end
    if (!en) begin
      m_st = 0; m_b = 0; m_w = 0;
    end else if (m_st == 0) begin
      if (a) begin m_st = 1; m_b = 0; m_w = 0; end
    end else if (m_st == 1) begin
      m_w++;
      if (b) m_b++;
      if (b && m_b == REP_N) begin
        if (c) begin e.pass = 1; m_st = 2; end
        else   begin e.fail = 1; m_st = 0; end
      end else if (m_w == MAX_WAIT) begin
        e.vac = 1; m_st = 0;
      end
    end else begin
      if (b)      m_st = 0;
      else if (c) e.pass = 1;
      else begin  e.fail = 1; m_st = 0; end
    end
    if (e.pass) begin m_pc = sat(m_pc, BIG_MAX); m_spc = sat(m_spc, SML_MAX); end
    if (e.fail) begin m_fc = sat(m_fc, BIG_MAX); m_sfc = sat(m_sfc, SML_MAX); end
    e.busy = (m_st != 0);
    e.pc = m_pc; e.fc = m_fc; e.dc = m_dc;
    e.spc = m_spc; e.sfc = m_sfc; e.sdc = m_sdc;
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("busy",       32'(busy_o),     32'(e.busy));
    check("pass",       32'(pass_o),     32'(e.pass));
    check("fail",       32'(fail_o),     32'(e.fail));
    check("vacuous",    32'(vacuous_o),  32'(e.vac));
    check("pass_cnt",   32'(pass_cnt_o), 32'(e.pc));
    check("fail_cnt",   32'(fail_cnt_o), 32'(e.fc));
    check("drop_cnt",   32'(drop_cnt_o), 32'(e.dc));
    check("s_pass",     32'(s_pass),     32'(e.pass));
    check("s_pass_cnt", 32'(s_pass_cnt), 32'(e.spc));
    check("s_fail_cnt", 32'(s_fail_cnt), 32'(e.sfc));
    check("s_drop_cnt", 32'(s_drop_cnt), 32'(e.sdc));
  endtask

  task automatic step(input bit en, input bit a, input bit b, input bit c);
    @(negedge clk);
    rst = 1'b0; en_i = en; a_i = a; b_i = b; c_i = c;
    model_step(en, a, b, c);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; a_i = 1'b0; b_i = 1'b0; c_i = 1'b0;
    do_reset();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_pass_cnt", 32'(pass_cnt_o), 32'd0);

    // Three match points then a fourth B ends the attempt.
    idle(2);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    check("s1_first_pass", 32'(pass_o), 32'd1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    check("s1_no_pass_b4", 32'(pass_o), 32'd0);
    check("s1_busy_drop", 32'(busy_o), 32'd0);
    check("s1_pass_cnt", 32'(pass_cnt_o), 32'd3);
    idle(2);
    do_reset();

    // Fail at the match point; an A on that cycle is a drop.
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(1, 1, 1, 0);
    check("s2_fail", 32'(fail_o), 32'd1);
    check("s2_busy", 32'(busy_o), 32'd0);
    check("s2_fail_cnt", 32'(fail_cnt_o), 32'd1);
    check("s2_pass_cnt", 32'(pass_cnt_o), 32'd0);
    check("s2_drop_cnt", 32'(drop_cnt_o), 32'd1);
    idle(2);
    do_reset();

    // Only two Bs within MAX_WAIT cycles: vacuous on the 64th.
    step(1, 1, 0, 0);
    for (int i = 1; i <= MAX_WAIT; i++) begin
      step(1, 0, (i == 5 || i == 30), 1);
      if (i == MAX_WAIT - 1) check("s3_no_vac_early", 32'(vacuous_o), 32'd0);
    end
    check("s3_vacuous", 32'(vacuous_o), 32'd1);
    check("s3_busy", 32'(busy_o), 32'd0);
    idle(2);
    do_reset();

    // Third B lands on the timeout cycle: match wins.
    step(1, 1, 0, 0);
    for (int i = 1; i <= MAX_WAIT; i++)
      step(1, 0, (i == 1 || i == 2 || i == MAX_WAIT), (i == MAX_WAIT));
    check("s4_pass_at_limit", 32'(pass_o), 32'd1);
    check("s4_no_vacuous", 32'(vacuous_o), 32'd0);
    step(0, 0, 0, 0);
    do_reset();

    // Extra As during COUNT are dropped; one attempt evaluated.
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    step(0, 0, 0, 0);
    check("s5_drop_cnt", 32'(drop_cnt_o), 32'd2);
    check("s5_pass_cnt", 32'(pass_cnt_o), 32'd1);
    do_reset();

    // Disable mid-attempt, then a fresh attempt counts from zero.
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(0, 1, 0, 1);
    check("s6_abort_busy", 32'(busy_o), 32'd0);
    step(1, 0, 1, 1);
    idle(5);
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    check("s6_fresh_count", 32'(pass_o), 32'd0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    check("s6_fresh_pass", 32'(pass_o), 32'd1);
    check("s6_drop_cnt", 32'(drop_cnt_o), 32'd0);
    do_reset();

    // 21 passes: the 4-bit counter sticks at 15; reset mid-CHECK clears all.
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1);
    check("s7_small_sat", 32'(s_pass_cnt), 32'd15);
    check("s7_big_cnt", 32'(pass_cnt_o), 32'd21);
    do_reset();
    check("s7_rst_busy", 32'(busy_o), 32'd0);
    check("s7_rst_pass_cnt", 32'(pass_cnt_o), 32'd0);
    check("s7_rst_small_cnt", 32'(s_pass_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(($urandom % 16) != 0, ($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nonconsec_rep_monitor.md
Name: nonconsec_rep_monitor

Overview:
- Synthesizable run-time checker for the rule "A, then starting next cycle B asserted exactly REP_N times (not necessarily consecutive) ⇒ C high at every match point."
- Sits downstream of the A/B/C stimulus/event sources in the sequence-checker bench and consumes those three strobes.
- Emits per-check pass/fail pulses and saturating statistics counters, so the same rule can be scored in silicon or FPGA without SVA.

Parameters:
- REP_N, 3, required number of B occurrences after A (≥1).
- MAX_WAIT, 64, max cycles spent in COUNT before the attempt is abandoned as vacuous (≥REP_N).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  check enable; low acts as disable-iff (abort, no result).
- a_i  in  1  trigger strobe.
- b_i  in  1  counted event strobe.
- c_i  in  1  consequent level, sampled at each match point.
- busy_o  out  1  attempt in progress (state != IDLE).
- pass_o  out  1  one-cycle pulse: c_i was high at a match point.
- fail_o  out  1  one-cycle pulse: c_i was low at a match point.
- vacuous_o  out  1  one-cycle pulse: COUNT timed out with fewer than REP_N Bs.
- pass_cnt_o  out  CNT_W  saturating count of pass_o pulses.
- fail_cnt_o  out  CNT_W  saturating count of fail_o pulses.
- drop_cnt_o  out  CNT_W  saturating count of a_i pulses ignored while not in IDLE.

Behaviour:
- Reset: state=IDLE; b count=0; wait count=0; all outputs 0, including counters.
- All pulses are registered. A pulse reflects the inputs of the cycle immediately before the pulse (1-cycle latency).
- IDLE:
  - en_i && a_i → COUNT, with b count=0 and wait count=0.
  - b_i and c_i are ignored in the A cycle; counting starts the next cycle.
- COUNT, each cycle:
  - wait count increments.
  - If b_i: b count increments. If the new value equals REP_N, this cycle is a match point: check c_i, pulse pass_o or fail_o. On pass → CHECK; on fail → IDLE.
  - Else if wait count reaches MAX_WAIT: pulse vacuous_o → IDLE.
- CHECK, each cycle:
  - If b_i: this is the (REP_N+1)th B. The antecedent no longer matches, so no check is made → IDLE.
  - Else: this is another match point. Check c_i; pass stays in CHECK, fail → IDLE.
  - CHECK has no timeout.
- Priority in COUNT: a B that completes REP_N on the same cycle the wait count reaches MAX_WAIT is treated as a match point, not vacuous.
- en_i low in any state:
  - Immediate → IDLE next cycle, counts cleared, no pulse for that cycle.
  - a_i is not accepted and not counted as a drop.
- a_i high while state != IDLE and en_i high increments drop_cnt. This includes the cycle in which the FSM returns to IDLE; one outstanding attempt only.
- Counters saturate at all-ones and never wrap.
- pass_o, fail_o and vacuous_o are mutually exclusive per cycle.
- rst mid-attempt: the attempt is discarded, no pulse, and counters clear.

Decomposition:
- Package nonconsec_mon_pkg:
  - state enum (IDLE, COUNT, CHECK).
  - localparam widths: $clog2(REP_N+1) for the b count, $clog2(MAX_WAIT+1) for the wait count.
  - function sat_inc for the counters.
- One sub-module sat_counter (CNT_W, inc, clr), instantiated three times.
- FSM and the two counts stay in the top module.

Test Plan:
- A@cycle 10; B@11,13,15; C high 15–17; B@18 → pass_o pulses for match cycles 15,16,17 (3 pulses); none for 18; pass_cnt=3; busy_o drops after 18.
- A@10; B@11,12,13; C low @13 → fail_o for cycle 13 only; FSM IDLE; fail_cnt=1; pass_cnt=0.
- A@10; only two Bs in the following 64 cycles → vacuous_o for cycle 74 (wait count hits 64); no pass/fail.
- A@10, A@12, A@14 during COUNT → drop_cnt=2; only one attempt is evaluated.
- A@10; B@11,12; en_i low @13 → no pulse; IDLE; B@14 is ignored; a new A@20 starts from b count=0.
- Force 2^CNT_W+5 passes (CNT_W=4 build) → pass_cnt_o sticks at 15; also rst mid-CHECK → all counters 0, busy_o 0 next cycle.
